c_sub_arb: RTL and testbench
============================

C_SUB_ARB -- requirements
Module: c_sub_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the subtractor (legal 2..8).
REQ-002 Parameter CNT_W, default 16, width of the accepted-operation counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_vld  input  N_REQ  per-requester operation request.
REQ-006 req_a  input  N_REQ*15  subtrahend A; requester i occupies bits [15*i+14:15*i].
REQ-007 req_b  input  N_REQ*15  minuend B; same packing as req_a.
REQ-008 req_rdy  output  N_REQ  one-hot-or-zero acceptance strobe.
REQ-009 rsp_vld  output  1  result valid.
REQ-010 rsp_rdy  input  1  consumer ready.
REQ-011 rsp_id  output  3  index of the requester that owns the result.
REQ-012 rsp_s  output  15  result B - A modulo 2^15.
REQ-013 rsp_borrow  output  1  high when A > B, unsigned.
REQ-014 op_cnt  output  CNT_W  count of accepted operations.

Function
REQ-015 Transfer in: a request is accepted in a cycle when req_vld[i] and req_rdy[i] are both high.
REQ-016 Transfer out: a result is consumed in a cycle when rsp_vld and rsp_rdy are both high.
REQ-017 Arbitration is round-robin: requester index rr_ptr has highest priority, then rr_ptr+1, and so on, wrapping modulo N_REQ.
REQ-018 rr_ptr resets to 0.
REQ-019 After each accepted request, rr_ptr becomes (granted index + 1) mod N_REQ; otherwise rr_ptr holds.
REQ-020 can_accept = (state == EMPTY) or (rsp_vld and rsp_rdy).
REQ-021 req_rdy[i] is high only for the arbitration winner, and only while can_accept is high.
REQ-022 req_rdy is combinational from req_vld, rr_ptr and the state; it never depends on req_a or req_b.
REQ-023 Requesters hold req_vld, req_a and req_b stable until accepted; the block may not drop a raised req_vld.
REQ-024 Output register FSM has two states, EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume with no accept.
  - FULL stays FULL on consume with a same-cycle accept (back-to-back, full throughput).
  - FULL stays FULL while rsp_rdy is low.
REQ-025 rsp_vld equals (state == FULL).
REQ-026 Latency: the result is visible on rsp_* in the cycle after acceptance.
REQ-027 rsp_s = B - A truncated to 15 bits, so wrap-around is allowed; for example A=1, B=0 gives 0x7FFF with borrow 1.
REQ-028 rsp_id, rsp_s and rsp_borrow are registered and stay stable while rsp_vld is high and rsp_rdy is low.
REQ-029 rsp_* values are don't-care while rsp_vld is low, but they do not toggle (they hold their last value).
REQ-030 op_cnt increments by 1 per accepted request and saturates at all-ones; it does not wrap.
REQ-031 A requester granted with req_vld deasserting in the same cycle is protocol misuse; the bench flags it with an assertion.

Reset
REQ-032 On rst_n low, asynchronously:
  - state = EMPTY, rsp_vld = 0, rsp_id = 0, rsp_s = 0, rsp_borrow = 0, op_cnt = 0, rr_ptr = 0.
  - req_rdy = 0 while reset is asserted.
REQ-033 Reset during FULL discards the pending result; no response is emitted after reset deasserts.
REQ-034 Deassertion is synchronized externally; the first accept is permitted on the first rising edge after release.

Structure
REQ-035 A shared package c_sub_pkg holds DATA_W = 15, ID_W = 3 and the state encoding EMPTY = 0, FULL = 1.
REQ-036 The single sub-module is the team's existing c_sub subtractor, instantiated once with A/B driven from the arbitration-winner mux.
REQ-037 The borrow is computed beside c_sub as a 16-bit compare; c_sub itself is not modified.

Verification
REQ-038 Single request: req_vld=0001, A=0x0003, B=0x0010 -> req_rdy=0001 that cycle; next cycle rsp_vld=1, rsp_id=0, rsp_s=0x000D, rsp_borrow=0; op_cnt=1.
REQ-039 Wrap and borrow: A=0x0001, B=0x0000 on requester 2 -> rsp_id=2, rsp_s=0x7FFF, rsp_borrow=1.
REQ-040 Fairness: req_vld=1111 held with rsp_rdy=1 -> grants go to 0,1,2,3,0 on consecutive cycles; rsp_vld stays high every cycle (full throughput).
REQ-041 Backpressure: rsp_rdy=0 for 5 cycles while FULL -> req_rdy=0000 throughout and rsp_* unchanged; when rsp_rdy rises, consume and the next accept occur in the same cycle.
REQ-042 Reset mid-operation: rst_n pulled low while FULL with rsp_rdy=0 -> rsp_vld=0 and op_cnt=0 immediately, and after release no stale result appears.
REQ-043 Saturation: CNT_W=4 with 20 accepted requests -> op_cnt=0xF and holds.

Source files
------------

// File: rtl/c_sub_pkg.sv
// Shared widths, output-register state encoding and the borrow helper for the
// arbitrated subtractor.
package c_sub_pkg;

  localparam int DATA_W = 15;
  localparam int ID_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Widen by one bit so the compare is unsigned and never overflows.
  function automatic logic borrow_of(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    return ({1'b0, a} > {1'b0, b});
  endfunction

endpackage

// File: rtl/c_sub_arb_if.sv
// Request fan-in and single response channel of the arbitrated subtractor.
// slave is the arbiter side, master is the requester/consumer side.
interface c_sub_arb_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  import c_sub_pkg::*;

  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        req_rdy;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_s;
  logic                    rsp_borrow;
  logic [CNT_W-1:0]        op_cnt;

  modport slave (
    input  req_vld, req_a, req_b, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_s, rsp_borrow, op_cnt
  );

  modport master (
    output req_vld, req_a, req_b, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_s, rsp_borrow, op_cnt
  );

endinterface

// File: rtl/c_sub.sv
// Combinational W-bit subtractor s = b - a (wraps modulo 2^W).
// Zero latency, no flow control.
module c_sub #(
  parameter int W = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  assign s = b - a;

endmodule

// File: rtl/c_sub_arb.sv
// Round-robin arbiter sharing one c_sub among N_REQ requesters; result registered, 1-cycle latency.
// req_rdy stays low while a held result is stalled; consume and the next accept may share a cycle.
module c_sub_arb
  import c_sub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  c_sub_arb_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] diff;
  logic              borrow;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] s_q;
  logic              borrow_q;
  logic [CNT_W-1:0]  cnt_q;

  assign can_accept = (state == EMPTY) || (bus.rsp_vld && bus.rsp_rdy);

  // Scan starting at rr_ptr; the first raised request wins.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req_vld[idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (rst_n && found && can_accept) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign accept      = |grant;
  assign bus.req_rdy = grant;
  assign next_ptr    = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign a_sel = bus.req_a[int'(win_idx)*DATA_W +: DATA_W];
  assign b_sel = bus.req_b[int'(win_idx)*DATA_W +: DATA_W];

  c_sub #(.W(DATA_W)) u_sub (
    .a (a_sel),
    .b (b_sel),
    .s (diff)
  );

  assign borrow = borrow_of(a_sel, b_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      id_q     <= '0;
      s_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      state    <= FULL;
      rr_ptr   <= next_ptr;
      id_q     <= ID_W'(win_idx);
      s_q      <= diff;
      borrow_q <= borrow;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (bus.rsp_vld && bus.rsp_rdy) begin
      state <= EMPTY;
    end
  end

  assign bus.rsp_vld    = (state == FULL);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_borrow = borrow_q;
  assign bus.op_cnt     = cnt_q;

endmodule

// File: tb/tb_c_sub_arb.sv
// Bench for c_sub_arb: directed scenarios plus randomized traffic against a
// behavioural model; a CNT_W=4 twin shares the stimulus to exercise saturation.
module tb_c_sub_arb;

  logic clk;
  logic rst_n;

  c_sub_arb_if #(.N_REQ(4), .CNT_W(16)) bus ();
  c_sub_arb_if #(.N_REQ(4), .CNT_W(4))  bus4 ();

  c_sub_arb #(.N_REQ(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  c_sub_arb #(.N_REQ(4), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  assign bus4.req_vld = bus.req_vld;
  assign bus4.req_a   = bus.req_a;
  assign bus4.req_b   = bus.req_b;
  assign bus4.rsp_rdy = bus.rsp_rdy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: a single output slot, the rotating priority and the accept count.
  int       m_full, m_rr, m_id, m_s, m_b, m_cnt;
  logic [3:0] acc;
  logic [3:0] pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_rr = 0; m_id = 0; m_s = 0; m_b = 0; m_cnt = 0;
    acc = '0; pend = '0;
  endtask

  // Runs at the falling edge: compare outputs, then advance the model over the next rising edge.
  task automatic model_eval();
    int g, i, a, b, can;
    logic [3:0] exp_rdy;
    if (!rst_n) begin
      model_reset();
      chk("rst_req_rdy", 32'(bus.req_rdy), 0);
      chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
      chk("rst_op_cnt",  32'(bus.op_cnt), 0);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (pend[k]) chk("proto_vld_held", 32'(bus.req_vld[k]), 1);
    end
    chk("m_rsp_vld",    32'(bus.rsp_vld), 32'(m_full));
    chk("m_rsp_id",     32'(bus.rsp_id), 32'(m_id));
    chk("m_rsp_s",      32'(bus.rsp_s), 32'(m_s));
    chk("m_rsp_borrow", 32'(bus.rsp_borrow), 32'(m_b));
    chk("m_op_cnt",     32'(bus.op_cnt), (m_cnt > 65535) ? 65535 : m_cnt);
    chk("m_op_cnt4",    32'(bus4.op_cnt), (m_cnt > 15) ? 15 : m_cnt);
    chk("m_rsp_vld4",   32'(bus4.rsp_vld), 32'(m_full));

    can = (!m_full || bus.rsp_rdy) ? 1 : 0;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      i = (m_rr + k) % 4;
      if (g < 0 && bus.req_vld[i]) g = i;
    end
    exp_rdy = (can != 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("m_req_rdy",  32'(bus.req_rdy), 32'(exp_rdy));
    chk("m_req_rdy4", 32'(bus4.req_rdy), 32'(exp_rdy));

    acc  = exp_rdy;
    pend = bus.req_vld & ~exp_rdy;
    if (exp_rdy != 0) begin
      a      = int'(bus.req_a[15*g +: 15]);
      b      = int'(bus.req_b[15*g +: 15]);
      m_s    = (b - a) & 32'h7FFF;
      m_b    = (a > b) ? 1 : 0;
      m_id   = g;
      m_full = 1;
      m_cnt++;
      m_rr   = (g + 1) % 4;
    end else if (m_full != 0 && bus.rsp_rdy) begin
      m_full = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b);
    bus.req_vld[i]         = v;
    bus.req_a[15*i +: 15]  = 15'(a);
    bus.req_b[15*i +: 15]  = 15'(b);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req_vld = '0;
    bus.rsp_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic int rnd_val();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r == 1) return 32'h7FFF;
    return $urandom_range(0, 32'h7FFF);
  endfunction

  initial begin
    model_reset();
    rst_n       = 1'b0;
    bus.req_vld = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.rsp_rdy = 1'b0;
    step();
    step();
    chk("reset_rsp_vld", 32'(bus.rsp_vld), 0);
    chk("reset_op_cnt",  32'(bus.op_cnt), 0);
    chk("reset_rsp_s",   32'(bus.rsp_s), 0);
    rst_n = 1'b1;

    // Single request on requester 0.
    set_req(0, 1'b1, 32'h0003, 32'h0010);
    bus.rsp_rdy = 1'b1;
    #1 chk("single_req_rdy", 32'(bus.req_rdy), 32'h1);
    step();
    bus.req_vld = '0;
    chk("single_rsp_vld", 32'(bus.rsp_vld), 1);
    chk("single_rsp_id",  32'(bus.rsp_id), 0);
    chk("single_rsp_s",   32'(bus.rsp_s), 32'h000D);
    chk("single_borrow",  32'(bus.rsp_borrow), 0);
    chk("single_op_cnt",  32'(bus.op_cnt), 1);
    step();

    // Wrap-around with borrow on requester 2.
    set_req(2, 1'b1, 32'h0001, 32'h0000);
    #1 chk("wrap_req_rdy", 32'(bus.req_rdy), 32'h4);
    step();
    bus.req_vld = '0;
    chk("wrap_rsp_id",  32'(bus.rsp_id), 2);
    chk("wrap_rsp_s",   32'(bus.rsp_s), 32'h7FFF);
    chk("wrap_borrow",  32'(bus.rsp_borrow), 1);
    step();

    // Fairness with all requesters raised and consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, i, 10 * i);
    bus.rsp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_grant", 32'(bus.req_rdy), 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("fair_rsp_vld", 32'(bus.rsp_vld), 1);
        chk("fair_rsp_id",  32'(bus.rsp_id), 32'((k - 1) % 4));
      end
      step();
    end

    // Backpressure: held result, no grants, then consume + accept together.
    do_reset();
    set_req(1, 1'b1, 5, 9);
    bus.rsp_rdy = 1'b0;
    #1 chk("bp_first_rdy", 32'(bus.req_rdy), 32'h2);
    step();
    bus.req_vld = '0;
    set_req(3, 1'b1, 2, 7);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_req_rdy", 32'(bus.req_rdy), 0);
      chk("bp_rsp_vld", 32'(bus.rsp_vld), 1);
      chk("bp_rsp_id",  32'(bus.rsp_id), 1);
      chk("bp_rsp_s",   32'(bus.rsp_s), 4);
      step();
    end
    bus.rsp_rdy = 1'b1;
    #1 chk("bp_release_rdy", 32'(bus.req_rdy), 32'h8);
    step();
    bus.req_vld = '0;
    chk("bp_next_vld", 32'(bus.rsp_vld), 1);
    chk("bp_next_id",  32'(bus.rsp_id), 3);
    chk("bp_next_s",   32'(bus.rsp_s), 5);
    step();
    chk("bp_drained", 32'(bus.rsp_vld), 0);

    // Asynchronous reset while a stalled result is held.
    set_req(0, 1'b1, 1, 2);
    bus.rsp_rdy = 1'b0;
    step();
    bus.req_vld = '0;
    chk("mid_full", 32'(bus.rsp_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.rsp_vld), 0);
    chk("mid_rst_cnt", 32'(bus.op_cnt), 0);
    step();
    rst_n       = 1'b1;
    bus.rsp_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_stale", 32'(bus.rsp_vld), 0);
    end

    // Randomized traffic; requesters hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i] || !bus.req_vld[i]) begin
          if ($urandom_range(0, 99) < 60) set_req(i, 1'b1, rnd_val(), rnd_val());
          else bus.req_vld[i] = 1'b0;
        end
      end
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) bus.req_vld[i] = 1'b0;
    end
    bus.rsp_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) bus.req_vld[i] = 1'b0;
      end
      step();
    end
    chk("sat_op_cnt4", 32'(bus4.op_cnt), 32'hF);
    chk("end_idle",    32'(bus.rsp_vld), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
